// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into a level pulse of programmable width,
// with optional holdoff, retrigger, dropped-trigger flag and accepted count.
module pulse_stretcher #(
  parameter int CW = 32,
  parameter int NW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          trig_i,
  input  logic [CW-1:0] width_i,
  input  logic [CW-1:0] holdoff_i,
  input  logic          retrigger_i,
  output logic          out_o,
  output logic          busy_o,
  output logic          missed_o,
  output logic [NW-1:0] trig_cnt_o
);

  typedef enum logic [1:0] {IDLE, HIGH, HOLDOFF} state_t;

  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [NW-1:0] N_ONE = NW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          retrig_q;

  wire width_ok = (width_i != '0);

  // out_o/busy_o are written alongside every state change so they stay
  // exact registered decodes of the state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      retrig_q   <= 1'b0;
      out_o      <= 1'b0;
      busy_o     <= 1'b0;
      missed_o   <= 1'b0;
      trig_cnt_o <= '0;
    end else begin
      missed_o <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_i && width_ok) begin
            state      <= HIGH;
            out_o      <= 1'b1;
            busy_o     <= 1'b1;
            cnt        <= width_i - C_ONE;
            retrig_q   <= retrigger_i;
            trig_cnt_o <= trig_cnt_o + N_ONE;
          end
        end
        HIGH: begin
          if (trig_i && retrig_q && width_ok) begin
            cnt        <= width_i - C_ONE;
            retrig_q   <= retrigger_i;
            trig_cnt_o <= trig_cnt_o + N_ONE;
          end else begin
            missed_o <= trig_i;
            if (cnt != '0) begin
              cnt <= cnt - C_ONE;
            end else if (holdoff_i == '0) begin
              state  <= IDLE;
              out_o  <= 1'b0;
              busy_o <= 1'b0;
            end else begin
              state <= HOLDOFF;
              out_o <= 1'b0;
              cnt   <= holdoff_i - C_ONE;
            end
          end
        end
        HOLDOFF: begin
          missed_o <= trig_i;
          if (cnt == '0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          out_o  <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle trigger pulses, such as rising-edge detector outputs, back into a level output of programmable width. An optional holdoff interval follows each output pulse, and a retrigger mode can extend a pulse that is already running. The block sits downstream of the edge detectors in the trigger path and drives slow-responding or externally routed consumers: DIO pins, LEDs and scope external-trigger inputs. It also reports dropped triggers and keeps a running count of accepted ones.

## Interface
Parameters:
- CW, 32: width of the width and holdoff counters.
- NW, 16: width of the accepted-trigger counter.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- trig_i  in  1  trigger; each high cycle is one trigger event. A held level produces one event per cycle.
- width_i  in  CW  output pulse width in clock cycles; 0 disables the block (triggers ignored and not counted).
- holdoff_i  in  CW  dead time in cycles after the pulse ends; 0 means no holdoff.
- retrigger_i  in  1  1: a trigger while the output is high restarts the width count.
- out_o  out  1  stretched output level, registered.
- busy_o  out  1  high in any state other than IDLE, registered.
- missed_o  out  1  one-cycle pulse for each trigger that is dropped, registered.
- trig_cnt_o  out  NW  count of accepted triggers; wraps from 2^NW-1 to 0.

## Operation
- FSM states: IDLE, HIGH, HOLDOFF. The down-counter cnt is CW bits wide.
- IDLE, when trig_i=1 and width_i!=0:
  - next state HIGH, cnt <= width_i-1, trig_cnt_o increments.
- IDLE, when trig_i=1 and width_i==0:
  - stay in IDLE; no count, no missed pulse.
- HIGH, normal progress:
  - if cnt!=0, cnt decrements.
  - if cnt==0 and holdoff_i==0, go to IDLE.
  - if cnt==0 and holdoff_i!=0, go to HOLDOFF with cnt <= holdoff_i-1.
- HIGH, when trig_i=1:
  - retrigger_i=1 and width_i!=0: cnt <= width_i-1 and stay in HIGH, including on the cycle where cnt==0. trig_cnt_o increments.
  - otherwise: the trigger is dropped and missed_o pulses.
- HOLDOFF:
  - every trigger is dropped and missed_o pulses.
  - if cnt==0, go to IDLE; otherwise cnt decrements.
- width_i and retrigger_i are sampled when a trigger is accepted. holdoff_i is sampled on the HIGH→HOLDOFF transition. Changing these inputs mid-pulse does not affect a count already loaded.
- Outputs are Moore decodes of the registered state:
  - out_o = (state==HIGH)
  - busy_o = (state!=IDLE)
- missed_o and trig_cnt_o are registered alongside the state update.
- Reset: state=IDLE, cnt=0, out_o=0, busy_o=0, missed_o=0, trig_cnt_o=0.
  - Reset asserted mid-pulse forces all of these immediately (asynchronously).
  - The first trigger after rstn_i deasserts is accepted normally.

## Timing
- Latency: a trigger sampled at edge k drives out_o high from edge k+1.
- Without retrigger, out_o stays high for exactly width_i cycles, then is low for at least max(holdoff_i,1) cycles before it can rise again.
  - With holdoff_i=0, the mandatory low cycle is the single IDLE cycle.
- A retrigger accepted at edge j keeps out_o high through edge j+width_i, i.e. exactly width_i more cycles counted from edge j+1.
- A trigger in the last HOLDOFF cycle is dropped. Only a trigger sampled while in IDLE is accepted.
- missed_o goes high for the one cycle after the dropped trigger's edge. Consecutive dropped triggers give consecutive high cycles.
- trig_cnt_o updates on the same edge as the accepting state transition.
- Maximum pulse width is 2^CW-1 cycles. No arithmetic underflow: cnt is only decremented when nonzero.

## Test plan
- Basic pulse: width_i=5, holdoff_i=0, one trig_i pulse at cycle 10 → out_o high for cycles 11–15, busy_o high for the same cycles, trig_cnt_o=1, missed_o never asserts.
- Holdoff drop: width_i=3, holdoff_i=4, triggers at 10 and 15 → out_o high 11–13, busy_o high 11–17, trigger at 15 dropped with missed_o high at cycle 16, trig_cnt_o=1. A trigger at 18 is accepted and out_o rises at 19.
- Retrigger: width_i=4, retrigger_i=1, triggers at 10 and 12 → out_o high 11–16 continuously (6 cycles), trig_cnt_o=2. The same stimulus with retrigger_i=0 → out_o high 11–14, missed_o high at 13, trig_cnt_o=1.
- Held level: trig_i high for 20 cycles, width_i=2, holdoff_i=0, retrigger_i=0 → out_o repeats a pattern of 2 cycles high, 1 cycle low. Every trigger that is neither in IDLE nor accepted pulses missed_o.
- Disable and wrap: with width_i=0, any triggers → out_o, missed_o and trig_cnt_o unchanged. With NW=4, 17 accepted triggers → trig_cnt_o=1.
- Async reset: assert rstn_i low mid-HIGH with cnt at 100, between clock edges → out_o and busy_o drop at once, all outputs read 0. After release, a trigger gives a full width_i pulse.
